jtag_tap_responder: RTL and testbench

- Synthesizable IEEE 1149.1 TAP responder: 16-state TAP controller, 5-bit IR, BYPASS, IDCODE and one user data register.
- It is the target-side end of the JTAG link that our host-side scan sequences drive (IR scan, DR scan, Pause-DR path, clocked reset).
- Provides capture/update strobes and parallel data to downstream debug logic (e.g. a DMI/AXI-lite front end).
- Runs entirely in the tck domain; no system clock.

---
 rtl/jtag_tap_responder.sv | 159 +++++++++++++++
 tb/tb_jtag_tap_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_responder.sv
// Target-side IEEE 1149.1 TAP: 16-state controller, IR, BYPASS, IDCODE and one user DR.
// Everything runs on tck: the controller and shift paths use the rising edge, tdo and updates use the falling edge.
module jtag_tap_responder #(
  parameter int                   IR_LENGTH    = 5,
  parameter logic [31:0]          IDCODE_VALUE = 32'hdeadbeef,
  parameter int                   DR_WIDTH     = 51,
  parameter logic [IR_LENGTH-1:0] USER_IR      = 5'h11
) (
  input  logic                 tck_i,
  input  logic                 trst_,
  input  logic                 tms_i,
  input  logic                 tdi_i,
  output logic                 tdo_o,
  output logic                 tdo_oe_o,
  output logic [3:0]           tap_state_o,
  output logic [IR_LENGTH-1:0] ir_o,
  input  logic [DR_WIDTH-1:0]  user_capture_i,
  output logic                 user_capture_o,
  output logic                 user_update_o,
  output logic [DR_WIDTH-1:0]  user_data_o
);

  localparam logic [3:0] TLR      = 4'hF;
  localparam logic [3:0] RTI      = 4'hC;
  localparam logic [3:0] SEL_DR   = 4'h7;
  localparam logic [3:0] CAP_DR   = 4'h6;
  localparam logic [3:0] SH_DR    = 4'h2;
  localparam logic [3:0] EX1_DR   = 4'h1;
  localparam logic [3:0] PAUSE_DR = 4'h3;
  localparam logic [3:0] EX2_DR   = 4'h0;
  localparam logic [3:0] UPD_DR   = 4'h5;
  localparam logic [3:0] SEL_IR   = 4'h4;
  localparam logic [3:0] CAP_IR   = 4'hE;
  localparam logic [3:0] SH_IR    = 4'hA;
  localparam logic [3:0] EX1_IR   = 4'h9;
  localparam logic [3:0] PAUSE_IR = 4'hB;
  localparam logic [3:0] EX2_IR   = 4'h8;
  localparam logic [3:0] UPD_IR   = 4'hD;

  localparam logic [IR_LENGTH-1:0] IR_IDCODE  = {{(IR_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [IR_LENGTH-1:0] IR_CAPTURE = {{(IR_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]          IDCODE_CAP = IDCODE_VALUE | 32'h1;

  logic [3:0]           state_q, state_d;
  logic [IR_LENGTH-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]          id_sr_q, id_sr_d;
  logic                 byp_q, byp_d;
  logic [DR_WIDTH-1:0]  usr_sr_q, usr_sr_d;
  logic [IR_LENGTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0]  udata_q, udata_d;
  logic                 tdo_q, tdo_d;
  logic                 oe_q, oe_d;
  logic                 sel_user, sel_id;

  assign sel_user = (ir_q == USER_IR);
  assign sel_id   = !sel_user && (ir_q == IR_IDCODE);

  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:      state_d = tms_i ? TLR      : RTI;
      RTI:      state_d = tms_i ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms_i ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms_i ? EX1_DR   : SH_DR;
      SH_DR:    state_d = tms_i ? EX1_DR   : SH_DR;
      EX1_DR:   state_d = tms_i ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms_i ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_d = tms_i ? UPD_DR   : SH_DR;
      UPD_DR:   state_d = tms_i ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms_i ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms_i ? EX1_IR   : SH_IR;
      SH_IR:    state_d = tms_i ? EX1_IR   : SH_IR;
      EX1_IR:   state_d = tms_i ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms_i ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_d = tms_i ? UPD_IR   : SH_IR;
      UPD_IR:   state_d = tms_i ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  // All DR shift registers capture together; only the selected one shifts.
  always_comb begin
    ir_sr_d  = ir_sr_q;
    id_sr_d  = id_sr_q;
    byp_d    = byp_q;
    usr_sr_d = usr_sr_q;
    case (state_q)
      CAP_IR: ir_sr_d = IR_CAPTURE;
      SH_IR:  ir_sr_d = {tdi_i, ir_sr_q[IR_LENGTH-1:1]};
      CAP_DR: begin
        id_sr_d  = IDCODE_CAP;
        byp_d    = 1'b0;
        usr_sr_d = user_capture_i;
      end
      SH_DR: begin
        if (sel_user)    usr_sr_d = {tdi_i, usr_sr_q[DR_WIDTH-1:1]};
        else if (sel_id) id_sr_d  = {tdi_i, id_sr_q[31:1]};
        else             byp_d    = tdi_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck_i or posedge trst_) begin
    if (trst_) begin
      state_q  <= TLR;
      ir_sr_q  <= '0;
      id_sr_q  <= '0;
      byp_q    <= 1'b0;
      usr_sr_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_sr_q  <= ir_sr_d;
      id_sr_q  <= id_sr_d;
      byp_q    <= byp_d;
      usr_sr_q <= usr_sr_d;
    end
  end

  always_comb begin
    tdo_d   = 1'b0;
    oe_d    = (state_q == SH_DR) || (state_q == SH_IR);
    ir_d    = ir_q;
    udata_d = udata_q;
    if (state_q == SH_IR) tdo_d = ir_sr_q[0];
    if (state_q == SH_DR) begin
      if (sel_user)    tdo_d = usr_sr_q[0];
      else if (sel_id) tdo_d = id_sr_q[0];
      else             tdo_d = byp_q;
    end
    if (state_q == TLR)    ir_d = IR_IDCODE;
    if (state_q == UPD_IR) ir_d = ir_sr_q;
    if (state_q == UPD_DR && sel_user) udata_d = usr_sr_q;
  end

  always_ff @(negedge tck_i or posedge trst_) begin
    if (trst_) begin
      tdo_q   <= 1'b0;
      oe_q    <= 1'b0;
      ir_q    <= IR_IDCODE;
      udata_q <= '0;
    end else begin
      tdo_q   <= tdo_d;
      oe_q    <= oe_d;
      ir_q    <= ir_d;
      udata_q <= udata_d;
    end
  end

  // Strobes span exactly the Capture-DR / Update-DR state cycle.
  assign user_capture_o = (state_q == CAP_DR) && sel_user;
  assign user_update_o  = (state_q == UPD_DR) && sel_user;
  assign tdo_o          = tdo_q;
  assign tdo_oe_o       = oe_q;
  assign tap_state_o    = state_q;
  assign ir_o           = ir_q;
  assign user_data_o    = udata_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed scans against jtag_tap_responder; expected tdo bits are queued by the driver
// and checked by a falling-edge monitor whenever tdo_oe_o is high.
module tb_jtag_tap_responder;

  logic        tck_i = 1'b0;
  logic        trst_ = 1'b1;
  logic        tms_i = 1'b1;
  logic        tdi_i = 1'b0;
  logic        tdo_o;
  logic        tdo_oe_o;
  logic [3:0]  tap_state_o;
  logic [4:0]  ir_o;
  logic [50:0] user_capture_i;
  logic        user_capture_o;
  logic        user_update_o;
  logic [50:0] user_data_o;

  localparam logic [50:0] CAPV = 51'h1234_5678_9ABC;
  localparam logic [50:0] DIN  = {17'h15555, 32'hfaceb00c, 2'h2};
  localparam logic [50:0] DIN2 = 51'h7_0F0F_0F0F_0F0F;

  jtag_tap_responder dut (
    .tck_i          (tck_i),
    .trst_          (trst_),
    .tms_i          (tms_i),
    .tdi_i          (tdi_i),
    .tdo_o          (tdo_o),
    .tdo_oe_o       (tdo_oe_o),
    .tap_state_o    (tap_state_o),
    .ir_o           (ir_o),
    .user_capture_i (user_capture_i),
    .user_capture_o (user_capture_o),
    .user_update_o  (user_update_o),
    .user_data_o    (user_data_o)
  );

  always #5 tck_i = ~tck_i;

  int   total = 0;
  int   bad   = 0;
  int   oe_cnt = 0;
  int   upd_cnt = 0;
  int   cap_cnt = 0;
  logic exp_q[$];

  always @(negedge tck_i) begin
    logic e;
    #2;
    if (tdo_oe_o) begin
      oe_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tdo_unexpected got=%b want=none", tdo_o);
      end else begin
        e = exp_q.pop_front();
        if (tdo_o !== e) begin
          bad++;
          $display("FAIL tdo_bit got=%b want=%b", tdo_o, e);
        end
      end
    end
    if (user_update_o)  upd_cnt++;
    if (user_capture_o) cap_cnt++;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    tms_i = t;
    tdi_i = d;
    @(posedge tck_i);
    #1;
  endtask

  // Full scan from RTI back to RTI; optional Pause-DR excursion after pause_after bits.
  task automatic scan(input bit is_ir, input int n, input logic [255:0] din,
                      input logic [255:0] exp, input int pause_after, input bit end_pause);
    for (int i = 0; i < n; i++) exp_q.push_back(exp[i]);
    step(1'b1, 1'b0);
    if (is_ir) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      bit last = (i == n - 1);
      bit pz   = (pause_after > 0) && (i + 1 == pause_after) && !last;
      step(last || pz, din[i]);
      if (pz) begin
        repeat (10) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
      end
    end
    if (end_pause) begin
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic dr_partial(input int nshift, input int npush);
    for (int i = 0; i < npush; i++) exp_q.push_back(CAPV[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < nshift; i++) step(1'b0, DIN[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int oe0, upd0, cap0;
    user_capture_i = CAPV;
    #13;
    chk("rst_state",  256'(tap_state_o), 256'h0F);
    chk("rst_ir",     256'(ir_o), 256'h01);
    chk("rst_tdo",    256'({tdo_o, tdo_oe_o}), 256'h0);
    chk("rst_strobe", 256'({user_capture_o, user_update_o}), 256'h0);
    chk("rst_udata",  256'(user_data_o), 256'h0);
    trst_ = 1'b0;
    @(posedge tck_i); #1;
    repeat (5) step(1'b1, 1'b0);
    chk("tlr_state", 256'(tap_state_o), 256'h0F);
    step(1'b0, 1'b0);
    chk("rti_state", 256'(tap_state_o), 256'h0C);

    oe0 = oe_cnt;
    scan(1'b0, 32, 256'h0, 256'hdeadbeef, 0, 1'b0);
    chk("idcode_oe_cnt", 256'(oe_cnt - oe0), 256'd32);

    scan(1'b1, 5, 256'h00, 256'h01, 0, 1'b0);
    chk("ir_bypass", 256'(ir_o), 256'h00);
    scan(1'b0, 8, 256'hA5, 256'h4A, 0, 1'b0);

    scan(1'b1, 5, 256'h11, 256'h01, 0, 1'b0);
    chk("ir_user", 256'(ir_o), 256'h11);
    upd0 = upd_cnt; cap0 = cap_cnt;
    scan(1'b0, 51, 256'(DIN), 256'(CAPV), 0, 1'b1);
    chk("user_pause_end", 256'(user_data_o), 256'(DIN));
    chk("user_upd_once",  256'(upd_cnt - upd0), 256'd1);
    chk("user_cap_once",  256'(cap_cnt - cap0), 256'd1);
    scan(1'b0, 51, 256'(DIN2), 256'(CAPV), 0, 1'b0);
    chk("user_early2", 256'(user_data_o), 256'(DIN2));
    scan(1'b0, 51, 256'(DIN), 256'(CAPV), 0, 1'b0);
    chk("user_early", 256'(user_data_o), 256'(DIN));

    scan(1'b1, 5, 256'h10, 256'h01, 0, 1'b0);
    upd0 = upd_cnt; cap0 = cap_cnt;
    scan(1'b0, 8, 256'h3C, 256'h78, 0, 1'b0);
    chk("ir10_strobes", 256'({upd_cnt - upd0, cap_cnt - cap0}), 256'h0);
    chk("ir10_udata",   256'(user_data_o), 256'(DIN));
    scan(1'b1, 5, 256'h1f, 256'h01, 0, 1'b0);
    chk("ir_1f", 256'(ir_o), 256'h1f);
    upd0 = upd_cnt; cap0 = cap_cnt;
    scan(1'b0, 8, 256'hC3, 256'h86, 0, 1'b0);
    chk("ir1f_strobes", 256'({upd_cnt - upd0, cap_cnt - cap0}), 256'h0);
    chk("ir1f_udata",   256'(user_data_o), 256'(DIN));

    // Abort by TMS mid user-DR shift.
    scan(1'b1, 5, 256'h11, 256'h01, 0, 1'b0);
    dr_partial(20, 21);
    repeat (5) step(1'b1, 1'b0);
    chk("abortA_state", 256'(tap_state_o), 256'h0F);
    @(negedge tck_i); #2;
    chk("abortA_ir", 256'(ir_o), 256'h01);
    step(1'b0, 1'b0);

    // Abort by trst_ mid user-DR shift.
    scan(1'b1, 5, 256'h11, 256'h01, 0, 1'b0);
    upd0 = upd_cnt;
    dr_partial(20, 20);
    trst_ = 1'b1;
    #2;
    chk("abortB_state",  256'(tap_state_o), 256'h0F);
    chk("abortB_ir",     256'(ir_o), 256'h01);
    chk("abortB_tdo",    256'({tdo_o, tdo_oe_o}), 256'h0);
    chk("abortB_strobe", 256'({user_capture_o, user_update_o}), 256'h0);
    chk("abortB_udata",  256'(user_data_o), 256'h0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    trst_ = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("abortB_hold_tlr", 256'(tap_state_o), 256'h0F);
    step(1'b0, 1'b0);
    chk("abortB_rti", 256'(tap_state_o), 256'h0C);
    chk("abortB_no_upd", 256'(upd_cnt - upd0), 256'd0);

    // Pause-DR in the middle of a user scan.
    scan(1'b1, 5, 256'h11, 256'h01, 0, 1'b0);
    scan(1'b0, 51, 256'(DIN), 256'(CAPV), 20, 1'b0);
    chk("pause_mid_udata", 256'(user_data_o), 256'(DIN));

    repeat (3) step(1'b0, 1'b0);
    chk("queue_drained", 256'(exp_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
